// File: rtl/shift_add_mul_ctrl.sv
// shift_add_mul_ctrl: sequential shift-add multiplier (control FSM + C/A/Q/M datapath)
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, a, b       multiply request and operands, accepted only in IDLE
//   k                 terminal flag from the external iteration counter (count == WIDTH-1)
//   cnt_load          one-cycle counter load pulse, issued in LOAD
//   busy              high in LOAD and all ITER cycles
//   done, product     one-cycle strobe with the 2*WIDTH-bit result, held until next result
// Option: define SHIFT_ADD_MUL_SIGNED_EN for two's complement operands and result.
module shift_add_mul_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               k,
    output logic               cnt_load,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0]   m_r, a_r, q_r, m_in, q_in;
    logic               c_r;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] res, prod_nx;
    logic               accept;
    assign accept = state == S_IDLE && start;
    // sum carry lands in A's MSB and the sum LSB shifts into Q's MSB
    assign sum = {c_r, a_r} + {1'b0, q_r[0] ? m_r : {WIDTH{1'b0}}};
    assign res = {sum, q_r[WIDTH-1:1]};
`ifdef SHIFT_ADD_MUL_SIGNED_EN
    logic neg;
    assign m_in    = a[WIDTH-1] ? -a : a;
    assign q_in    = b[WIDTH-1] ? -b : b;
    assign prod_nx = neg ? -res : res;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            neg <= 1'b0;
        else if (accept)
            neg <= a[WIDTH-1] ^ b[WIDTH-1];
`else
    assign m_in    = a;
    assign q_in    = b;
    assign prod_nx = res;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    always_comb begin
        state_nx = state == S_IDLE ? (start ? S_LOAD : S_IDLE) :
                   state == S_LOAD ? S_ITER :
                   state == S_ITER ? (k ? S_DONE : S_ITER) : S_IDLE;
    end
    always_comb begin
        cnt_load = state == S_LOAD;
        busy     = state == S_LOAD || state == S_ITER;
        done     = state == S_DONE;
    end
    // product is loaded on the last ITER edge so it is already valid while done is high
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_r     <= '0;
            a_r     <= '0;
            q_r     <= '0;
            c_r     <= 1'b0;
            product <= '0;
        end else if (accept) begin
            m_r <= m_in;
            q_r <= q_in;
            a_r <= '0;
            c_r <= 1'b0;
        end else if (state == S_ITER) begin
            c_r        <= 1'b0;
            {a_r, q_r} <= res;
            if (k)
                product <= prod_nx;
        end
endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// tb_shift_add_mul_ctrl: directed scoreboard bench for shift_add_mul_ctrl with a counter model
module tb_shift_add_mul_ctrl;
    logic        clk, rst_n, start, k, cnt_load, busy, done;
    logic [7:0]  a_i, b_i;
    logic [15:0] product;
    logic [2:0]  cnt;
    logic [15:0] sb[$];
    int          checks, passes;

    shift_add_mul_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_i), .b(b_i), .k(k),
        .cnt_load(cnt_load), .busy(busy), .done(done), .product(product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= cnt_load ? 3'd0 : cnt + 3'd1;
    assign k = cnt == 3'd7;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic mul(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp_p,
                       input string tag, input bit glitch, input bit done_start);
        int lat, loads;
        logic [15:0] e;
        @(negedge clk);
        a_i = x; b_i = y; start = 1'b1;
        sb.push_back(exp_p);
        @(negedge clk);
        start = 1'b0; a_i = 8'hAA; b_i = 8'h55;
        lat = 1; loads = cnt_load ? 1 : 0;
        chk({tag, " cnt_load@1"}, 32'(cnt_load), 32'd1);
        chk({tag, " busy@1"}, 32'(busy), 32'd1);
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (cnt_load) loads++;
            start = glitch && lat == 4;
        end
        start = 1'b0;
        e = sb.pop_front();
        chk({tag, " latency"}, 32'(lat), 32'd10);
        chk({tag, " loads"}, 32'(loads), 32'd1);
        chk({tag, " busy@done"}, 32'(busy), 32'd0);
        chk({tag, " product"}, 32'(product), 32'(e));
        start = done_start;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " done pulse"}, 32'(done), 32'd0);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        chk({tag, " idle load"}, 32'(cnt_load), 32'd0);
        chk({tag, " held"}, 32'(product), 32'(e));
    endtask

    initial begin
        checks = 0; passes = 0;
        start = 1'b0; a_i = '0; b_i = '0; rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst product", 32'(product), 32'd0);
            chk("rst done", 32'(done), 32'd0);
            chk("rst busy", 32'(busy), 32'd0);
            chk("rst load", 32'(cnt_load), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        mul(8'd13, 8'd11, 16'd143, "13x11", 1'b0, 1'b0);
`ifdef SHIFT_ADD_MUL_SIGNED_EN
        mul(8'hFD, 8'd7, 16'hFFEB, "-3x7", 1'b0, 1'b0);
        mul(8'h80, 8'h80, 16'h4000, "-128x-128", 1'b0, 1'b0);
`else
        mul(8'd255, 8'd255, 16'hFE01, "255x255", 1'b0, 1'b0);
`endif
        mul(8'd0, 8'd200, 16'h0000, "0x200", 1'b0, 1'b0);
        mul(8'd6, 8'd7, 16'd42, "6x7 busy-start", 1'b1, 1'b1);
        @(negedge clk);
        a_i = 8'd100; b_i = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("midop busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midop rst product", 32'(product), 32'd0);
        chk("midop rst busy", 32'(busy), 32'd0);
        chk("midop rst done", 32'(done), 32'd0);
        chk("midop rst load", 32'(cnt_load), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mul(8'd5, 8'd9, 16'd45, "5x9 after rst", 1'b0, 1'b0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/shift_add_mul_ctrl.md
Name: shift_add_mul_ctrl

Overview:
- Shift-add multiplier core: control FSM plus accumulator/multiplier datapath for the sequential multiplier.
- Sits directly downstream of the iteration counter. It drives the counter's load input and consumes the counter's terminal flag k to end the iteration loop.
- Accepts one operand pair per start pulse and returns a 2*WIDTH-bit product with a one-cycle done strobe.

Parameters:
- WIDTH, 8, operand width in bits. The product is 2*WIDTH bits. The paired counter must assert k when its count equals WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- start  input  1  request a multiply; sampled only in IDLE
- a  input  WIDTH  multiplicand; captured on accepted start
- b  input  WIDTH  multiplier; captured on accepted start
- k  input  1  counter terminal flag; high during the last iteration cycle
- cnt_load  output  1  one-cycle load pulse to the counter (count := 0)
- busy  output  1  high from the LOAD state through the last ITER cycle
- done  output  1  one-cycle strobe; product valid
- product  output  2*WIDTH  result; held until the next accepted start

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, cnt_load=0, busy=0, done=0, product=0, all internal registers=0. Takes effect mid-operation too; no partial result is kept.
- Internal registers:
  - M: WIDTH bits, multiplicand.
  - C: 1 bit, carry.
  - A: WIDTH bits, accumulator.
  - Q: WIDTH bits, multiplier / low product.
- IDLE:
  - If start=1, capture M=a, Q=b, clear A and C, then go to LOAD.
  - done is low in IDLE except in its strobe cycle.
- LOAD (1 cycle):
  - cnt_load=1 and busy=1.
  - Next state is ITER. The counter reads 0 during the first ITER cycle.
- ITER (exactly WIDTH cycles for a conforming counter):
  - busy=1.
  - Each cycle: sum = {C,A} + (Q[0] ? M : 0), computed at WIDTH+1 bits. Then {C,A,Q} := {1'b0, sum, Q} >> 1, so the sum's carry moves into A's MSB.
  - If k=1 in this cycle, this is the last iteration; next state is DONE. Otherwise stay in ITER.
- DONE (1 cycle):
  - product := {A,Q}, done=1, busy=0.
  - Next state is IDLE.
  - product is registered so that it is valid in the same cycle done=1.
- Latency: start sampled at edge 0 → done high in cycle WIDTH+2, i.e. 10 cycles for WIDTH=8. Zero operands take the same latency.
- Input handling:
  - start while busy or in DONE is ignored; no queuing.
  - k outside ITER is ignored.
  - a and b changing after capture have no effect.
- Back-to-back: start asserted in the done cycle is ignored. A start in the following IDLE cycle is accepted.
- Arithmetic: unsigned, exact, no overflow possible. Max case: (2^WIDTH-1)^2.

Optional Feature:
- Macro: SHIFT_ADD_MUL_SIGNED_EN
- Defined: a and b are two's complement.
  - At capture, M=|a| and Q=|b|; the sign bit neg = a[MSB]^b[MSB] is registered.
  - In DONE, product = neg ? -{A,Q} : {A,Q}, a 2*WIDTH-bit two's complement result.
  - Latency is unchanged.
- Undefined: unsigned only. No neg register and no negation logic.

Test Plan:
- Reset then idle: rst_n low 3 cycles, start=0 → product=0x0000, done=0, busy=0, cnt_load=0 throughout.
- Basic multiply: a=13, b=11, start 1 cycle, with a counter model (k at count 7) → cnt_load high 1 cycle after start; done exactly 10 cycles after start; product=143 (0x008F), held until the next start.
- Extremes: a=255, b=255 → product=0xFE01. Then a=0, b=200 → product=0x0000, still at 10-cycle latency.
- Start while busy: start pulsed again 4 cycles into a=6, b=7 → ignored; done once; product=42; no second cnt_load.
- Reset mid-op: rst_n low during the 5th ITER cycle of a=100, b=3 → all outputs 0 immediately. After release, a=5, b=9 → product=45 with normal latency.
- Signed (SHIFT_ADD_MUL_SIGNED_EN): a=-3 (0xFD), b=7 → product=0xFFEB (-21). Then a=-128, b=-128 → product=0x4000.
